mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 24 ++
 rtl/mul_div_unit_sign_fix.sv | 17 +
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_div_pkg;

  // Operation encodings carried on op_i.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Signed variants are the ones with bit 0 clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
// Latency: combinational.
// Backpressure: none.
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    data_o = neg_i ? (~data_i + W'(1)) : data_i;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one shift-add/shift-subtract step per cycle.
// Latency: WIDTH cycles from the accepting edge to the HI/LO load; divide-by-zero completes after 1 edge.
// Backpressure: start_i is only accepted while not busy; requests during RUN are dropped.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               dz_pend_q, dz_pend_d;
  logic               is_mul_q, is_mul_d;
  logic               res_neg_q, res_neg_d;   // product / quotient sign
  logic               rem_neg_q, rem_neg_d;   // remainder follows the dividend
  logic [WIDTH-1:0]   m_q, m_d;               // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   wa_q, wa_d;             // partial-product high half / partial remainder
  logic [WIDTH-1:0]   wb_q, wb_d;             // multiplier bits / quotient bits
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               src_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg;

  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               sub_en;
  logic [WIDTH-1:0]   wa_n, wb_n;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;
  logic               accept;

  assign src_signed = op_is_signed(op_i);
  assign a_neg      = src_signed & src1_i[WIDTH-1];
  assign b_neg      = src_signed & src2_i[WIDTH-1];

  sign_fix #(.W(WIDTH)) u_fix_src1 (.data_i(src1_i), .neg_i(a_neg), .data_o(a_mag));
  sign_fix #(.W(WIDTH)) u_fix_src2 (.data_i(src2_i), .neg_i(b_neg), .data_o(b_mag));

  // One shared adder: add-if-bit-set for multiply, trial subtract for divide.
  always_comb begin
    if (is_mul_q) begin
      sub_en = 1'b0;
      add_a  = {1'b0, wa_q};
      add_b  = wb_q[0] ? {1'b0, m_q} : '0;
    end else begin
      sub_en = 1'b1;
      add_a  = {wa_q, wb_q[WIDTH-1]};
      add_b  = {1'b0, m_q};
    end
    add_sum = add_a + (sub_en ? ~add_b : add_b) + {{WIDTH{1'b0}}, sub_en};
  end

  // Next working registers: right shift for multiply, restoring left shift for divide.
  always_comb begin
    if (is_mul_q) begin
      wa_n = add_sum[WIDTH:1];
      wb_n = {add_sum[0], wb_q[WIDTH-1:1]};
    end else if (!add_sum[WIDTH]) begin
      wa_n = add_sum[WIDTH-1:0];
      wb_n = {wb_q[WIDTH-2:0], 1'b1};
    end else begin
      wa_n = add_a[WIDTH-1:0];
      wb_n = {wb_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction is applied to the final-iteration value as it is loaded.
  sign_fix #(.W(2*WIDTH)) u_fix_prod (.data_i({wa_n, wb_n}), .neg_i(res_neg_q), .data_o(prod_fix));
  sign_fix #(.W(WIDTH))   u_fix_quo  (.data_i(wb_n), .neg_i(res_neg_q), .data_o(quo_fix));
  sign_fix #(.W(WIDTH))   u_fix_rem  (.data_i(wa_n), .neg_i(rem_neg_q), .data_o(rem_fix));

  assign hi_res = is_mul_q ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
  assign lo_res = is_mul_q ? prod_fix[WIDTH-1:0]       : quo_fix;

  // A zero-divisor request occupies one IDLE cycle (dz_pend) and blocks new starts meanwhile.
  assign accept = start_i && (state_q != RUN) && !dz_pend_q;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    dz_pend_d = 1'b0;
    is_mul_d  = is_mul_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    m_d       = m_q;
    wa_d      = wa_q;
    wb_d      = wb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      RUN: begin
        wa_d  = wa_n;
        wb_d  = wb_n;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_res;
          lo_d    = lo_res;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (dz_pend_q) begin
          done_d  = 1'b1;
          dz_d    = 1'b1;
          state_d = DONE;
        end
      end
    endcase

    if (accept) begin
      if (op_i[1] && (src2_i == '0)) begin
        state_d   = IDLE;
        dz_pend_d = 1'b1;
      end else begin
        state_d   = RUN;
        cnt_d     = CNT_W'(WIDTH);
        is_mul_d  = !op_i[1];
        res_neg_d = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        wa_d      = '0;
        m_d       = op_i[1] ? b_mag : a_mag;
        wb_d      = op_i[1] ? a_mag : b_mag;
      end
    end

    busy_d = (state_d == RUN);
  end

  // All state, including the registered status outputs, updates here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      is_mul_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      m_q       <= '0;
      wa_q      <= '0;
      wb_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      dz_pend_q <= dz_pend_d;
      is_mul_q  <= is_mul_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      m_q       <= m_d;
      wa_q      <= wa_d;
      wb_q      <= wb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32.
// Latency: checks exact completion timing relative to the accepting edge.
// Backpressure: exercises ignored mid-RUN starts and starts issued in DONE.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int WIDTH = 32;

  logic             clk_i   = 1'b0;
  logic             rst_i   = 1'b1;
  logic             start_i = 1'b0;
  logic [1:0]       op_i    = 2'b00;
  logic [WIDTH-1:0] src1_i  = '0;
  logic [WIDTH-1:0] src2_i  = '0;
  logic             busy_o, done_o, div_zero_o;
  logic [WIDTH-1:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request, let one rising edge accept it, then scramble the inputs.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i    = ~op;
    src1_i  = 32'hA5A5_5A5A;
    src2_i  = 32'h0;
  endtask

  // Wait for done_o; returns at the negedge where it is seen. Optionally pokes start_i mid-RUN.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input bit poke);
    int cyc = 0;
    int busy_cnt = 0;
    bit got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        cyc++;
      end
      start_i = 1'b0;
      if (poke && !got && cyc == 5) begin
        start_i = 1'b1;
        op_i    = OP_DIVU;
        src1_i  = 32'd9;
        src2_i  = 32'd0;
      end
    end
    check_val({tag, "_done_seen"}, 64'(got), 64'd1);
    check_val({tag, "_latency"}, 64'(cyc), 64'd32);
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check_val({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
    check_val({tag, "_dz_flag"}, 64'(div_zero_o), 64'd0);
    check_val({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  initial begin
    // Reset state.
    #12;
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_done", 64'(done_o), 64'd0);
    check_val("rst_dz", 64'(div_zero_o), 64'd0);
    check_val("rst_hi", 64'(hi_o), 64'd0);
    check_val("rst_lo", 64'(lo_o), 64'd0);

    // Start accepted on the first edge after reset release.
    @(negedge clk_i);
    rst_i = 1'b0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk_i);
    check_val("multu_done_pulse", 64'(done_o), 64'd0);

    // Signed multiply with an ignored start in the middle of RUN.
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);

    @(negedge clk_i);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    @(negedge clk_i);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

    @(negedge clk_i);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    // Preload HI/LO, then divide by zero.
    @(negedge clk_i);
    issue(OP_MULTU, 32'h1234_5678, 32'h10);
    wait_done("preload", 32'h0000_0001, 32'h2345_6780, 1'b0);
    @(negedge clk_i);
    issue(OP_DIVU, 32'd7, 32'd0);
    @(negedge clk_i);
    check_val("dz_e0_done", 64'(done_o), 64'd0);
    check_val("dz_e0_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    check_val("dz_e1_done", 64'(done_o), 64'd1);
    check_val("dz_e1_flag", 64'(div_zero_o), 64'd1);
    check_val("dz_e1_busy", 64'(busy_o), 64'd0);
    check_val("dz_hi", 64'(hi_o), 64'h1);
    check_val("dz_lo", 64'(lo_o), 64'h2345_6780);
    @(negedge clk_i);
    check_val("dz_e2_done", 64'(done_o), 64'd0);
    check_val("dz_e2_flag", 64'(div_zero_o), 64'd0);

    // Reset in the middle of a multiply, then restart straight away.
    @(negedge clk_i);
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'd3);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_val("abort_busy", 64'(busy_o), 64'd0);
    check_val("abort_done", 64'(done_o), 64'd0);
    check_val("abort_hi", 64'(hi_o), 64'd0);
    check_val("abort_lo", 64'(lo_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("restart", 32'h0000_0001, 32'h0000_0000, 1'b0);

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk_i);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("b2b_divu", 32'd2, 32'd14, 1'b0);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done("b2b_multu", 32'd0, 32'd42, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
